// File: rtl/regfile_param_if.sv
// -----------------------------------------------------------------------------
// regfile_param_if
// Bundles the write, read, clear and status signals of regfile_param.
//   master : the register-file user (decode stage / testbench). It drives
//            clr_req, we, wa, wd, err_inj and ra.
//   slave  : the register file itself. It drives rd, ready, clr_done and
//            par_err.
// Read ports are packed: port i uses ra[i*ADDR_W +: ADDR_W] and
// rd[i*DATA_W +: DATA_W].
// -----------------------------------------------------------------------------
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     clr_req;
   logic                     we;
   logic [ADDR_W-1:0]        wa;
   logic [DATA_W-1:0]        wd;
   logic                     err_inj;
   logic [NUM_RD*ADDR_W-1:0] ra;
   logic [NUM_RD*DATA_W-1:0] rd;
   logic                     ready;
   logic                     clr_done;
   logic [NUM_RD-1:0]        par_err;

   modport master (
      output clr_req, we, wa, wd, err_inj, ra,
      input  rd, ready, clr_done, par_err
   );

   modport slave (
      input  clr_req, we, wa, wd, err_inj, ra,
      output rd, ready, clr_done, par_err
   );
endinterface : regfile_param_if

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Parametrised multi-read / single-write register file for the decode stage.
// The array has no per-flop reset: after reset (or on clr_req) a sequential
// clear engine zeroes one entry per cycle, and the file reports ready once
// every entry has been cleared. Reads are combinational with a same-cycle
// write-to-read bypass.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   bus (slave)      clr_req, we, wa, wd, err_inj, ra  -> inputs
//                    rd, ready, clr_done, par_err      -> outputs
//
// Optional build macro
//   REGFILE_PARITY_EN  adds one even-parity bit per entry; err_inj stores the
//                      inverted parity, and par_err flags array reads whose
//                      data and parity disagree. Undefined: par_err is 0 and
//                      err_inj has no effect.
// -----------------------------------------------------------------------------
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input logic             clk,
   input logic             rst,
   regfile_param_if.slave  bus
);

   localparam int                DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic              ready_q;
   logic              clr_done_q;

   logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef REGFILE_PARITY_EN
   logic              par_q [DEPTH];
   logic              mem_wp_d;
`endif

   logic              wr_fire;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_wa_d;
   logic [DATA_W-1:0] mem_wd_d;

   // A user write lands only in IDLE, loses to a same-cycle clear request and
   // is dropped when it targets the hardwired zero entry.
   assign wr_fire = (state_q == S_IDLE) && bus.we && !bus.clr_req &&
                    !((ZERO_REG != 0) && (bus.wa == '0));

   // ---------------------------------------------------------------------------
   // Control FSM: CLEAR walks clr_cnt over every entry, IDLE serves the user.
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         clr_cnt_q  <= '0;
         ready_q    <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               clr_done_q <= 1'b0;
               if (clr_cnt_q == LAST) begin
                  state_q    <= S_IDLE;
                  ready_q    <= 1'b1;
                  clr_done_q <= 1'b1;
                  clr_cnt_q  <= '0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            S_IDLE: begin
               clr_done_q <= 1'b0;
               if (bus.clr_req) begin
                  state_q   <= S_CLEAR;
                  ready_q   <= 1'b0;
                  clr_cnt_q <= '0;
               end
            end
            default: begin
               state_q <= S_CLEAR;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.clr_done = clr_done_q;

   // ---------------------------------------------------------------------------
   // Single array write port, shared by the clear engine and user writes.
   // ---------------------------------------------------------------------------
   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      mem_we_d = wr_fire;
      mem_wa_d = bus.wa;
      mem_wd_d = bus.wd;
`ifdef REGFILE_PARITY_EN
      mem_wp_d = (^bus.wd) ^ bus.err_inj;
`endif
      if (state_q == S_CLEAR) begin
         mem_we_d = 1'b1;
         mem_wa_d = clr_cnt_q;
         mem_wd_d = '0;
`ifdef REGFILE_PARITY_EN
         mem_wp_d = 1'b0;
`endif
      end
   end

   // NOTE: the array deliberately has no reset so it maps onto plain storage;
   // its contents become defined through the clear engine, not through rst.
   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[mem_wa_d] <= mem_wd_d;
`ifdef REGFILE_PARITY_EN
         par_q[mem_wa_d] <= mem_wp_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Combinational read ports. Priority: zero entry, bypass, array.
   // Outputs stay at zero while the array is being cleared.
   // ---------------------------------------------------------------------------
   always_comb begin : read_mux
      logic [ADDR_W-1:0] ra_v;
      ra_v        = '0;
      bus.rd      = '0;
      bus.par_err = '0;
      if (state_q == S_IDLE) begin
         for (int i = 0; i < NUM_RD; i++) begin
            ra_v = bus.ra[i*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (ra_v == '0)) begin
               bus.rd[i*DATA_W +: DATA_W] = '0;
            end else if (wr_fire && (bus.wa == ra_v)) begin
               bus.rd[i*DATA_W +: DATA_W] = bus.wd;
            end else begin
               bus.rd[i*DATA_W +: DATA_W] = mem_q[ra_v];
`ifdef REGFILE_PARITY_EN
               // Even parity: data XOR stored bit is 0 for an intact entry.
               bus.par_err[i] = par_q[ra_v] ^ (^mem_q[ra_v]);
`endif
            end
         end
      end
   end

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
// Self-checking bench for regfile_param with default parameters. A plain
// array model holds the expected contents plus a per-entry "stored with
// injected parity error" flag; expected read data follows the zero-entry,
// bypass and array rules directly. Works with and without REGFILE_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_regfile_param;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_RD   = 2;
   localparam int ZERO_REG = 1;
   localparam int DEPTH    = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

   regfile_param #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] model_mem [DEPTH];
   bit                model_bad [DEPTH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.clr_req = 1'b0;
      bus.we      = 1'b0;
      bus.wa      = '0;
      bus.wd      = '0;
      bus.err_inj = 1'b0;
      bus.ra      = '0;
   endtask

   task automatic set_ra(input int i, input logic [ADDR_W-1:0] a);
      bus.ra[i*ADDR_W +: ADDR_W] = a;
   endtask

   function automatic logic [ADDR_W-1:0] get_ra(input int i);
      return bus.ra[i*ADDR_W +: ADDR_W];
   endfunction

   function automatic logic [DATA_W-1:0] rd_port(input int i);
      return bus.rd[i*DATA_W +: DATA_W];
   endfunction

   function automatic bit is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == 0);
   endfunction

   function automatic bit is_bypass(input logic [ADDR_W-1:0] a);
      return bus.we && !bus.clr_req && (bus.wa == a) && !is_zero(a);
   endfunction

   function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
      if (is_zero(a))   return '0;
      if (is_bypass(a)) return bus.wd;
      return model_mem[a];
   endfunction

   function automatic bit exp_perr(input logic [ADDR_W-1:0] a);
      if (is_zero(a) || is_bypass(a)) return 1'b0;
`ifdef REGFILE_PARITY_EN
      return model_bad[a];
`else
      return 1'b0;
`endif
   endfunction

   // Compare every read port against the model for the current inputs (IDLE).
   task automatic check_ports(input string tag);
      for (int i = 0; i < NUM_RD; i++) begin
         check($sformatf("%s_rd%0d_a%0d", tag, i, get_ra(i)), rd_port(i), exp_rd(get_ra(i)));
         check($sformatf("%s_perr%0d_a%0d", tag, i, get_ra(i)), bus.par_err[i], exp_perr(get_ra(i)));
      end
   endtask

   // Advance one IDLE cycle, committing the current write into the model.
   task automatic cycle();
      if (bus.we && !bus.clr_req && !is_zero(bus.wa)) begin
         model_mem[bus.wa] = bus.wd;
         model_bad[bus.wa] = bus.err_inj;
      end
      step();
   endtask

   task automatic clear_model();
      for (int a = 0; a < DEPTH; a++) begin
         model_mem[a] = '0;
         model_bad[a] = 1'b0;
      end
   endtask

   task automatic read_all(input string tag);
      bus.we      = 1'b0;
      bus.clr_req = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         for (int i = 0; i < NUM_RD; i++) set_ra(i, ADDR_W'(a));
         #1;
         check_ports(tag);
      end
   endtask

   // Count rising edges until ready rises; bounded so the bench cannot hang.
   task automatic count_to_ready(output int n);
      n = 0;
      while (!bus.ready && n < 100) begin
         step();
         n++;
      end
   endtask

   initial begin
      #200us;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      idle_inputs();
      clear_model();
      rst = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", bus.ready, 1'b0);
      check("rst_done", bus.clr_done, 1'b0);

      // Initial clear: ready and clr_done rise together on edge 32
      set_ra(0, 5'd1);
      set_ra(1, 5'd2);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!bus.ready && n < 100) begin
         step();
         n++;
         if (n == 5) begin
            check("clear_rd0_zero", rd_port(0), '0);
            check("clear_ready_low", bus.ready, 1'b0);
         end
      end
      check("init_edges", n, 32);
      check("init_done_hi", bus.clr_done, 1'b1);
      step();
      check("init_done_lo", bus.clr_done, 1'b0);
      check("init_ready_hold", bus.ready, 1'b1);
      read_all("init");

      // Same-cycle bypass, then array read on another port
      bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
      set_ra(0, 5'd5); set_ra(1, 5'd6);
      #1;
      check("byp_rd0", rd_port(0), 32'hDEADBEEF);
      check("byp_rd1_other", rd_port(1), 32'h0);
      cycle();
      bus.we = 1'b0;
      set_ra(1, 5'd5);
      #1;
      check("arr_rd1", rd_port(1), 32'hDEADBEEF);

      // Zero entry: write dropped, read returns 0 in and after the write cycle
      bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF;
      set_ra(0, 5'd0);
      #1;
      check("zero_wr_cycle", rd_port(0), 32'h0);
      cycle();
      bus.we = 1'b0;
      #1;
      check("zero_after", rd_port(0), 32'h0);

      // Randomized IDLE traffic against the model
      repeat (400) begin
         bus.we      = 1'($urandom_range(0, 1));
         bus.wa      = ADDR_W'($urandom);
         bus.wd      = $urandom;
         bus.err_inj = 1'($urandom_range(0, 3) == 0);
         for (int i = 0; i < NUM_RD; i++) begin
            if ($urandom_range(0, 3) == 0) set_ra(i, bus.wa);
            else                           set_ra(i, ADDR_W'($urandom));
         end
         #1;
         check_ports("rand");
         cycle();
      end
      bus.err_inj = 1'b0;
      read_all("rand_end");

      // Clear request beats a same-cycle write; mid-clear requests ignored
      bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h1234;
      cycle();
      bus.clr_req = 1'b1; bus.wd = 32'h5555;
      cycle();
      clear_model();
      bus.clr_req = 1'b0; bus.we = 1'b0;
      check("clr_ready_low", bus.ready, 1'b0);
      n = 0;
      while (!bus.ready && n < 100) begin
         bus.we      = 1'($urandom_range(0, 1));
         bus.wa      = ADDR_W'($urandom);
         bus.wd      = $urandom;
         bus.clr_req = (n == 10);
         set_ra(0, 5'd7);
         set_ra(1, bus.wa);
         #1;
         if (n == 3) begin
            check("clr_rd0_zero", rd_port(0), '0);
            check("clr_rd1_byp_zero", rd_port(1), '0);
            check("clr_perr_zero", bus.par_err, '0);
         end
         step();
         n++;
      end
      bus.we = 1'b0; bus.clr_req = 1'b0;
      check("clr_edges", n, 32);
      check("clr_done_hi", bus.clr_done, 1'b1);
      set_ra(0, 5'd7);
      #1;
      check("clr_entry7", rd_port(0), 32'h0);
      read_all("clr");

      // Reset in the middle of a clear restarts the sequence from entry 0
      bus.we = 1'b1; bus.wa = 5'd9; bus.wd = $urandom;
      cycle();
      bus.we = 1'b0;
      bus.clr_req = 1'b1;
      cycle();
      bus.clr_req = 1'b0;
      clear_model();
      repeat (10) step();
      rst = 1'b1;
      #1;
      check("midrst_ready", bus.ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      count_to_ready(n);
      check("midrst_edges", n, 32);
      check("midrst_done", bus.clr_done, 1'b1);
      read_all("midrst");

      // Parity: injected error flagged on array read, not on bypass
      bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hA5; bus.err_inj = 1'b1;
      set_ra(0, 5'd3);
      #1;
      check("par_byp_rd", rd_port(0), 32'hA5);
      check("par_byp_perr", bus.par_err[0], 1'b0);
      cycle();
      bus.we = 1'b0; bus.err_inj = 1'b0;
      #1;
      check("par_inj_rd", rd_port(0), 32'hA5);
`ifdef REGFILE_PARITY_EN
      check("par_inj_perr", bus.par_err[0], 1'b1);
`else
      check("par_inj_perr", bus.par_err[0], 1'b0);
`endif
      bus.we = 1'b1;
      cycle();
      bus.we = 1'b0;
      #1;
      check("par_ok_rd", rd_port(0), 32'hA5);
      check("par_ok_perr", bus.par_err[0], 1'b0);
      read_all("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_regfile_param
